// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key expander: one round key per clock into a 1408-bit schedule.
// Optional AES_KEY_STREAM_EN adds a per-round key stream (rk_valid/rk_index/rk_data).
package globals_aes;
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
endpackage

module aes_key_expansion #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [0:127]                      in_key,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [0:(NUM_ROUNDS+1)*128-1]     key_schedule
`ifdef AES_KEY_STREAM_EN
  ,
  output logic                              rk_valid,
  output logic [3:0]                        rk_index,
  output logic [0:127]                      rk_data
`endif
);

  localparam int SCHED_W = (NUM_ROUNDS + 1) * 128;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [0:SCHED_W-1] sched_q, sched_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [3:0]         round_cnt_q, round_cnt_d;

  logic [3:0]   prev_idx;
  logic [127:0] prev_key, next_key;
  logic [31:0]  p0, p1, p2, p3, rot, t, n0, n1, n2, n3;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return globals_aes::SBOX[8*int'(b) +: 8];
  endfunction

  // The previous round key is read back out of the schedule itself.
  assign prev_idx = (round_cnt_q == 4'd0) ? 4'd0 : round_cnt_q - 4'd1;
  assign prev_key = sched_q[128*int'(prev_idx) +: 128];
  assign {p0, p1, p2, p3} = prev_key;
  assign rot = {p3[23:0], p3[31:24]};
  assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon_q, 24'h0};
  assign n0 = p0 ^ t;
  assign n1 = p1 ^ n0;
  assign n2 = p2 ^ n1;
  assign n3 = p3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign key_schedule = sched_q;

  always_comb begin
    state_d     = state_q;
    sched_d     = sched_q;
    rcon_d      = rcon_q;
    round_cnt_d = round_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sched_d[0 +: 128] = in_key;
          rcon_d            = 8'h01;
          round_cnt_d       = 4'd1;
          state_d           = EXPAND;
        end
      end
      EXPAND: begin
        sched_d[128*int'(round_cnt_q) +: 128] = next_key;
        rcon_d      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
        round_cnt_d = round_cnt_q + 4'd1;
        if (round_cnt_q == 4'(NUM_ROUNDS)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sched_q     <= '0;
      rcon_q      <= 8'h01;
      round_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      sched_q     <= sched_d;
      rcon_q      <= rcon_d;
      round_cnt_q <= round_cnt_d;
    end
  end

`ifdef AES_KEY_STREAM_EN
  logic         rk_valid_q;
  logic [3:0]   rk_index_q;
  logic [0:127] rk_data_q;

  // Mirrors each schedule write so a downstream stage can start before DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_valid_q <= 1'b0;
      rk_index_q <= 4'd0;
      rk_data_q  <= '0;
    end else if (state_q == IDLE && in_valid) begin
      rk_valid_q <= 1'b1;
      rk_index_q <= 4'd0;
      rk_data_q  <= in_key;
    end else if (state_q == EXPAND) begin
      rk_valid_q <= 1'b1;
      rk_index_q <= round_cnt_q;
      rk_data_q  <= next_key;
    end else begin
      rk_valid_q <= 1'b0;
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_index = rk_index_q;
  assign rk_data  = rk_data_q;
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed self-checking bench for aes_key_expansion using FIPS-197 and all-zero key vectors.
// Build with AES_KEY_STREAM_EN defined to also check the round-key stream outputs.
module tb_aes_key_expansion;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [0:127]  in_key;
  logic          out_valid;
  logic          out_ready;
  logic [0:1407] key_schedule;
`ifdef AES_KEY_STREAM_EN
  logic          rk_valid;
  logic [3:0]    rk_index;
  logic [0:127]  rk_data;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] KEY1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY1_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] KEY1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY0      = 128'h0;
  localparam logic [127:0] KEY0_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KEY0_RK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] KEY0_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk = ~clk;

  aes_key_expansion #(.NUM_ROUNDS(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_key       (in_key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .key_schedule (key_schedule)
`ifdef AES_KEY_STREAM_EN
    ,
    .rk_valid     (rk_valid),
    .rk_index     (rk_index),
    .rk_data      (rk_data)
`endif
  );

  function automatic logic [127:0] rk(input int r);
    return key_schedule[r*128 +: 128];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_key = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    checks++;
    if (key_schedule !== '0) begin
      failures++;
      $display("[TB] FAIL reset_schedule: got nonzero, required 0");
    end
`ifdef AES_KEY_STREAM_EN
    checks++;
    if (rk_valid !== 1'b0 || rk_index !== 4'd0 || rk_data !== '0) begin
      failures++;
      $display("[TB] FAIL reset_stream: rk_valid=%b rk_index=%0d, required 0/0", rk_valid, rk_index);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Offers KEY1, scrambles in_key after acceptance, checks latency, slices and stream.
  task automatic test_vector1();
    int lat;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL v1_idle_ready: in_ready=%b required 1", in_ready);
    end
    in_key = KEY1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_key = '1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL v1_busy_ready: in_ready=%b required 0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
`ifdef AES_KEY_STREAM_EN
      checks++;
      if (rk_valid !== 1'b1 || rk_index !== 4'(lat) || rk_data !== rk(lat)) begin
        failures++;
        $display("[TB] FAIL stream_rk%0d: rk_valid=%b rk_index=%0d rk_data=%h", lat, rk_valid, rk_index, rk_data);
      end
`endif
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 10) begin
      failures++;
      $display("[TB] FAIL v1_latency: got %0d cycles, required 10", lat);
    end
`ifdef AES_KEY_STREAM_EN
    checks++;
    if (rk_valid !== 1'b1 || rk_index !== 4'd10 || rk_data !== KEY1_RK10) begin
      failures++;
      $display("[TB] FAIL stream_rk10: rk_valid=%b rk_index=%0d rk_data=%h", rk_valid, rk_index, rk_data);
    end
`endif
    checks++;
    if (rk(0) !== KEY1) begin
      failures++;
      $display("[TB] FAIL v1_rk0: got %h required %h", rk(0), KEY1);
    end
    checks++;
    if (rk(1) !== KEY1_RK1) begin
      failures++;
      $display("[TB] FAIL v1_rk1: got %h required %h", rk(1), KEY1_RK1);
    end
    checks++;
    if (rk(2) !== KEY1_RK2) begin
      failures++;
      $display("[TB] FAIL v1_rk2: got %h required %h", rk(2), KEY1_RK2);
    end
    checks++;
    if (rk(10) !== KEY1_RK10) begin
      failures++;
      $display("[TB] FAIL v1_rk10: got %h required %h", rk(10), KEY1_RK10);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL v1_done_hold: out_valid=%b required 1", out_valid);
    end
`ifdef AES_KEY_STREAM_EN
    checks++;
    if (rk_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stream_idle: rk_valid=%b required 0", rk_valid);
    end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL v1_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero_key();
    int lat;
    out_ready = 1'b0;
    in_key = KEY0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 10) begin
      failures++;
      $display("[TB] FAIL v0_latency: got %0d cycles, required 10", lat);
    end
    checks++;
    if (rk(1) !== KEY0_RK1) begin
      failures++;
      $display("[TB] FAIL v0_rk1: got %h required %h", rk(1), KEY0_RK1);
    end
    checks++;
    if (rk(2) !== KEY0_RK2) begin
      failures++;
      $display("[TB] FAIL v0_rk2: got %h required %h", rk(2), KEY0_RK2);
    end
    checks++;
    if (rk(10) !== KEY0_RK10) begin
      failures++;
      $display("[TB] FAIL v0_rk10: got %h required %h", rk(10), KEY0_RK10);
    end
  endtask

  // Continues from the DONE left by test_zero_key, with a competing key offered.
  task automatic test_hold_done();
    out_ready = 1'b0;
    in_key = KEY1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || rk(0) !== KEY0 ||
          rk(1) !== KEY0_RK1 || rk(10) !== KEY0_RK10) begin
        failures++;
        $display("[TB] FAIL hold_cycle%0d: out_valid=%b in_ready=%b rk0=%h rk10=%h", i, out_valid, in_ready, rk(0), rk(10));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hold_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_expand();
    int lat;
    out_ready = 1'b0;
    in_key = KEY1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || key_schedule !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_state: out_valid=%b in_ready=%b rk1=%h, required 0/1/0", out_valid, in_ready, rk(1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL midreset_quiet: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
      end
    end
    in_key = KEY1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 10 || rk(10) !== KEY1_RK10 || rk(1) !== KEY1_RK1) begin
      failures++;
      $display("[TB] FAIL midreset_rerun: lat=%0d rk10=%h, required 10/%h", lat, rk(10), KEY1_RK10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Second key stays offered throughout the first expansion and must only land after DONE.
  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    in_key = KEY1; in_valid = 1'b1;
    @(negedge clk);
    in_key = KEY0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 10 || rk(0) !== KEY1 || rk(1) !== KEY1_RK1 || rk(10) !== KEY1_RK10) begin
      failures++;
      $display("[TB] FAIL b2b_first: lat=%0d rk0=%h rk10=%h", lat, rk(0), rk(10));
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_done_one_cycle: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_second_accept: in_ready=%b required 0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 10 || rk(0) !== KEY0 || rk(1) !== KEY0_RK1 || rk(10) !== KEY0_RK10) begin
      failures++;
      $display("[TB] FAIL b2b_second: lat=%0d rk0=%h rk10=%h", lat, rk(0), rk(10));
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_final: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vector1();
    test_zero_key();
    test_hold_done();
    test_reset_mid_expand();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
